// File: rtl/param_switch_arbiter.sv
// N-requester switch arbiter with selectable fixed-priority or round-robin order,
// optional grant locking bounded by MAX_HOLD, and registered grant outputs.
module param_switch_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] i_Req,
  input  logic               i_Mode,
  input  logic               i_Hold,
  output logic [NUM_REQ-1:0] o_Gnt,
  output logic               o_Gnt_Valid,
  output logic [ID_W-1:0]    o_Gnt_Id
);

  localparam int HC_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

  state_t             r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [ID_W-1:0]    r_gnt_id, w_gnt_id_nxt;
  logic [ID_W-1:0]    r_ptr, w_ptr_nxt;
  logic [HC_W-1:0]    r_hold_cnt, w_hold_cnt_nxt;

  logic               w_keep;
  logic               w_win_found;
  logic [ID_W-1:0]    w_win_id;
  logic [ID_W-1:0]    w_idx;

  // Search order: descending from NUM_REQ-1 (fixed) or from ptr with wrap (round-robin).
  always_comb begin
    w_win_found = 1'b0;
    w_win_id    = '0;
    w_idx       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = i_Mode ? ID_W'((int'(r_ptr) + NUM_REQ - i) % NUM_REQ)
                     : ID_W'(NUM_REQ - 1 - i);
      if (!w_win_found && i_Req[w_idx]) begin
        w_win_found = 1'b1;
        w_win_id    = w_idx;
      end
    end
  end

  assign w_keep = (r_state == S_GRANT) && i_Hold && i_Req[r_gnt_id] &&
                  (r_hold_cnt < HC_W'(MAX_HOLD - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_gnt      <= '0;
      r_gnt_id   <= '0;
      r_ptr      <= ID_W'(NUM_REQ - 1);
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_gnt_id   <= w_gnt_id_nxt;
      r_ptr      <= w_ptr_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_nxt      = r_gnt;
    w_gnt_id_nxt   = r_gnt_id;
    w_ptr_nxt      = r_ptr;
    w_hold_cnt_nxt = r_hold_cnt;
    if (w_keep) begin
      w_hold_cnt_nxt = r_hold_cnt + 1'b1;
    end else begin
      // IDLE, or a grant that is released: arbitrate on the current requests.
      w_hold_cnt_nxt = '0;
      if (w_win_found) begin
        w_state_nxt  = S_GRANT;
        w_gnt_nxt    = NUM_REQ'(1) << w_win_id;
        w_gnt_id_nxt = w_win_id;
        w_ptr_nxt    = (w_win_id == '0) ? ID_W'(NUM_REQ - 1) : w_win_id - 1'b1;
      end else begin
        w_state_nxt  = S_IDLE;
        w_gnt_nxt    = '0;
        w_gnt_id_nxt = '0;
      end
    end
  end

  always_comb begin
    o_Gnt       = r_gnt;
    o_Gnt_Id    = r_gnt_id;
    o_Gnt_Valid = (r_state == S_GRANT);
  end

endmodule
